// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK levels and R/W bit values.
package i2c_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned ADDR_W = 7;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_WR_DATA  = 4'd3,
        ST_WR_ACK   = 4'd4,
        ST_RD_DATA  = 4'd5,
        ST_RD_ACK   = 4'd6
    } i2c_state_e;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_in_sync.sv
// SCL/SDA synchronizer with optional 3-sample glitch filter (I2C_TARGET_GLITCH_FILTER_EN),
// plus SCL edge and START/STOP detection from the accepted level and its one-clk history.
module i2c_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_c,
    output logic scl_rise_c,
    output logic scl_fall_c,
    output logic start_c,
    output logic stop_c
);

    localparam int unsigned NIN = 2;

    // bit 1 = SCL, bit 0 = SDA; all flops reset to the idle bus level
    logic [NIN-1:0] meta_q, meta_d;
    logic [NIN-1:0] sync_q, sync_d;
    logic [NIN-1:0] hist_q, hist_d;
    logic [NIN-1:0] lvl_c;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [NIN-1:0] smp1_q, smp1_d;
    logic [NIN-1:0] smp2_q, smp2_d;
    logic [NIN-1:0] filt_q, filt_d;
    logic [NIN-1:0] agree_c;

    // accept a new level only once three consecutive samples agree
    always_comb begin
        smp1_d  = sync_q;
        smp2_d  = smp1_q;
        agree_c = ~(sync_q ^ smp1_q) & ~(smp1_q ^ smp2_q);
        filt_d  = (agree_c & sync_q) | (~agree_c & filt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp1_q <= '1;
            smp2_q <= '1;
            filt_q <= '1;
        end else begin
            smp1_q <= smp1_d;
            smp2_q <= smp2_d;
            filt_q <= filt_d;
        end
    end

    assign lvl_c = filt_q;
`else
    assign lvl_c = sync_q;
`endif

    always_comb begin
        meta_d = {scl_in, sda_in};
        sync_d = meta_q;
        hist_d = lvl_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
            hist_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    // START/STOP need SCL high in both samples, so a simultaneous SCL/SDA change is neither
    assign sda_c      = lvl_c[0];
    assign scl_rise_c = lvl_c[1] & ~hist_q[1];
    assign scl_fall_c = ~lvl_c[1] & hist_q[1];
    assign start_c    = lvl_c[1] & hist_q[1] & hist_q[0] & ~lvl_c[0];
    assign stop_c     = lvl_c[1] & hist_q[1] & ~hist_q[0] & lvl_c[0];

endmodule

// File: rtl/i2c_target.sv
// Single-address I2C target: address match, ACK generation, byte write/read to a local port.
// Optional input glitch filter enabled by I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    logic sda_c, scl_rise_c, scl_fall_c, start_c, stop_c;

    i2c_in_sync u_in_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .sda_c      (sda_c),
        .scl_rise_c (scl_rise_c),
        .scl_fall_c (scl_fall_c),
        .start_c    (start_c),
        .stop_c     (stop_c)
    );

    i2c_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_req_q, tx_req_d;
    logic              busy_q, busy_d;
    logic              sda_oe_q, sda_oe_d;
    logic              rw_q, rw_d;
    // ACK states: set once the ACK is driven; RD_DATA: next fall loads tx_data
    logic              phase_q, phase_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;
        sda_oe_d   = sda_oe_q;
        rw_d       = rw_q;
        phase_d    = phase_q;

        if (start_c) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            phase_d   = 1'b0;
        end else if (stop_c) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            phase_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise_c) begin
                        shift_d   = {shift_q[DATA_W-2:0], sda_c};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(7)) begin
                            if (shift_q[ADDR_W-1:0] == SLAVE_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                                rw_d    = sda_c;
                                phase_d = 1'b0;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall_c) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else if (rw_q == RW_WRITE) begin
                            state_d   = ST_WR_DATA;
                            sda_oe_d  = 1'b0;
                            phase_d   = 1'b0;
                            bit_cnt_d = '0;
                        end else begin
                            // the fall ending the ACK bit also drives the first read bit
                            state_d   = ST_RD_DATA;
                            phase_d   = 1'b0;
                            sda_oe_d  = ~tx_data[DATA_W-1];
                            shift_d   = {tx_data[DATA_W-2:0], 1'b0};
                            bit_cnt_d = CNT_W'(1);
                        end
                    end else if (scl_rise_c && phase_q && (rw_q == RW_READ)) begin
                        tx_req_d = 1'b1;
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise_c) begin
                        shift_d   = {shift_q[DATA_W-2:0], sda_c};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(7)) begin
                            rx_data_d  = {shift_q[DATA_W-2:0], sda_c};
                            rx_valid_d = 1'b1;
                            state_d    = ST_WR_ACK;
                            phase_d    = 1'b0;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall_c) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = ST_WR_DATA;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall_c) begin
                        if (phase_q) begin
                            phase_d   = 1'b0;
                            sda_oe_d  = ~tx_data[DATA_W-1];
                            shift_d   = {tx_data[DATA_W-2:0], 1'b0};
                            bit_cnt_d = CNT_W'(1);
                        end else if (bit_cnt_q == '0) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            sda_oe_d  = ~shift_q[DATA_W-1];
                            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise_c) begin
                        if (sda_c == NACK) begin
                            state_d  = ST_IDLE;
                            busy_d   = 1'b0;
                            sda_oe_d = 1'b0;
                        end else begin
                            tx_req_d = 1'b1;
                            state_d  = ST_RD_DATA;
                            phase_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
            sda_oe_q   <= sda_oe_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-master tasks drive SCL/SDA, a monitor scoreboards rx_valid/tx_req.
module tb_i2c_target;

    localparam int Q = 10;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int n_txreq = 0;
    logic oe_seen = 1'b0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic [7:0] mon_exp;

    assign sda_bus = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (m_scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // scoreboard monitor: pops expectations when the DUT presents rx_valid or tx_req
    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (rx_valid) begin
            if (exp_rx.size() == 0) begin
                check("rx_valid_unexpected", 32'(rx_valid), 32'd0);
            end else begin
                mon_exp = exp_rx.pop_front();
                check("rx_data", 32'(rx_data), 32'(mon_exp));
            end
        end
        if (tx_req) begin
            n_txreq++;
            if (exp_tx.size() == 0) check("tx_req_unexpected", 32'(tx_req), 32'd0);
            else tx_data = exp_tx.pop_front();
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_cond();
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic stop_cond(input logic chk);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1;
        if (chk) begin
            wait_clk(LAT - 1);
            check("busy_before_stop_detect", 32'(busy), 32'd1);
            wait_clk(1);
            check("busy_after_stop", 32'(busy), 32'd0);
            wait_clk(Q - LAT);
        end else begin
            wait_clk(Q);
        end
    endtask

    task automatic bit_xfer(input logic b, input logic glitch, output logic s);
        m_sda = b;
        if (glitch) begin
            wait_clk(Q / 2);
            m_scl = 1'b1; wait_clk(2);
            m_scl = 1'b0; wait_clk(Q - Q / 2 - 2);
        end else begin
            wait_clk(Q);
        end
        m_scl = 1'b1; wait_clk(Q);
        s = sda_bus;  wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input int gbit, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], (i == gbit), s);
        bit_xfer(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, 1'b0, s);
            d[i] = s;
        end
        bit_xfer(m_ack, 1'b0, s);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         tx0;

        wait_clk(4);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_req", 32'(tx_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wait_clk(4);

        // write 0xA5, 0x3C to our address
        exp_rx.push_back(8'hA5);
        exp_rx.push_back(8'h3C);
        start_cond();
        write_byte(8'hA0, -1, ack); check("wr_addr_ack", 32'(ack), 32'd0);
        check("busy_addressed", 32'(busy), 32'd1);
        write_byte(8'hA5, -1, ack); check("wr_data0_ack", 32'(ack), 32'd0);
        write_byte(8'h3C, -1, ack); check("wr_data1_ack", 32'(ack), 32'd0);
        stop_cond(1'b1);
        check("wr_rx_pending", 32'(exp_rx.size()), 32'd0);

        // wrong address: no ACK, no drive at all
        oe_seen = 1'b0;
        start_cond();
        write_byte(8'hA2, -1, ack); check("bad_addr_nack", 32'(ack), 32'd1);
        write_byte(8'h33, -1, ack); check("bad_data_nack", 32'(ack), 32'd1);
        stop_cond(1'b0);
        check("bad_oe_never", 32'(oe_seen), 32'd0);
        check("bad_busy", 32'(busy), 32'd0);

        // read 0x96 (ACK) then 0x0F (NACK)
        tx0 = n_txreq;
        exp_tx.push_back(8'h96);
        exp_tx.push_back(8'h0F);
        start_cond();
        write_byte(8'hA1, -1, ack); check("rd_addr_ack", 32'(ack), 32'd0);
        read_byte(1'b0, rd); check("rd_byte0", 32'(rd), 32'h96);
        read_byte(1'b1, rd); check("rd_byte1", 32'(rd), 32'h0F);
        check("rd_busy_after_nack", 32'(busy), 32'd0);
        check("rd_txreq_count", 32'(n_txreq - tx0), 32'd2);
        stop_cond(1'b0);

        // write 0x12, repeated START, read 0x5A
        exp_rx.push_back(8'h12);
        exp_tx.push_back(8'h5A);
        start_cond();
        write_byte(8'hA0, -1, ack); check("rs_wr_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h12, -1, ack); check("rs_wr_data_ack", 32'(ack), 32'd0);
        start_cond();
        write_byte(8'hA1, -1, ack); check("rs_rd_addr_ack", 32'(ack), 32'd0);
        read_byte(1'b1, rd); check("rs_rd_byte", 32'(rd), 32'h5A);
        check("rs_rx_data_hold", 32'(rx_data), 32'h12);
        stop_cond(1'b0);

        // reset while the target drives a 0 data bit
        exp_tx.push_back(8'h7F);
        start_cond();
        write_byte(8'hA1, -1, ack); check("rst_rd_addr_ack", 32'(ack), 32'd0);
        check("oe_before_reset", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("oe_in_reset", 32'(sda_oe), 32'd0);
        wait_clk(2);
        rst_n = 1'b1;
        oe_seen = 1'b0;
        read_byte(1'b1, rd); check("post_rst_read_released", 32'(rd), 32'hFF);
        write_byte(8'h55, -1, ack); check("post_rst_nack", 32'(ack), 32'd1);
        stop_cond(1'b0);
        check("post_rst_oe_never", 32'(oe_seen), 32'd0);

        // fresh START after reset is answered again
        exp_rx.push_back(8'h81);
        start_cond();
        write_byte(8'hA0, -1, ack); check("fresh_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h81, -1, ack); check("fresh_data_ack", 32'(ack), 32'd0);
        stop_cond(1'b0);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // 2-clk SCL glitch inside a data bit must not shift an extra bit
        exp_rx.push_back(8'hC3);
        start_cond();
        write_byte(8'hA0, -1, ack); check("gl_addr_ack", 32'(ack), 32'd0);
        write_byte(8'hC3, 4, ack); check("gl_data_ack", 32'(ack), 32'd0);
        stop_cond(1'b0);
        check("gl_rx_data", 32'(rx_data), 32'hC3);
`endif

        wait_clk(10);
        check("rx_queue_empty", 32'(exp_rx.size()), 32'd0);
        check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
